nios_gpio_pio: RTL and testbench

- Parametrised Avalon-MM slave GPIO port; the next generation of the single-register output-only PIO that drives the rover's bit-banged I2C and control lines.
- Adds per-bit direction, open-drain mode, synchronised input readback, atomic set/clear, edge capture and a level interrupt to the Nios.
- Sits between the Nios II data master (through the interconnect) and the FPGA pads.

---
 rtl/nios_gpio_pkg.sv | 15 +
 rtl/nios_gpio_sync_edge.sv | 55 +++++
 rtl/nios_gpio_pio.sv | 103 ++++++++++
 tb/tb_nios_gpio_pio.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/nios_gpio_pkg.sv
// Shared register map and edge-type encodings for the Nios GPIO port.
package nios_gpio_pkg;

    localparam logic [2:0] ADDR_DATA = 3'd0;
    localparam logic [2:0] ADDR_DIR  = 3'd1;
    localparam logic [2:0] ADDR_MASK = 3'd2;
    localparam logic [2:0] ADDR_EDGE = 3'd3;
    localparam logic [2:0] ADDR_SET  = 3'd4;
    localparam logic [2:0] ADDR_CLR  = 3'd5;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/nios_gpio_sync_edge.sv
// Pad input synchroniser, one-cycle history register and edge pulse generation.
module nios_gpio_sync_edge
    import nios_gpio_pkg::*;
#(
    parameter int WIDTH       = 7,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_TYPE   = EDGE_ANY
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] pad_in,
    output logic [WIDTH-1:0] sync,
    output logic [WIDTH-1:0] edge_pulse
);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync_d [SYNC_STAGES];
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] prev_d;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;

    always_comb begin
        sync_d[0] = pad_in;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
        prev_d = sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            prev_q <= '0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign sync = sync_q[SYNC_STAGES-1];

    always_comb begin
        rise = sync & ~prev_q;
        fall = ~sync & prev_q;
        case (EDGE_TYPE)
            EDGE_RISE: edge_pulse = rise;
            EDGE_FALL: edge_pulse = fall;
            default:   edge_pulse = rise | fall;
        endcase
    end

endmodule

// File: rtl/nios_gpio_pio.sv
// Avalon-MM GPIO slave: direction, open-drain option, atomic set/clear,
// edge capture and a level interrupt to the Nios.
module nios_gpio_pio
    import nios_gpio_pkg::*;
#(
    parameter int               WIDTH       = 7,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter logic [WIDTH-1:0] RESET_DIR   = '0,
    parameter int               OPEN_DRAIN  = 0,
    parameter int               EDGE_TYPE   = EDGE_ANY,
    parameter int               SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] pad_in,
    output logic [WIDTH-1:0] pad_out,
    output logic [WIDTH-1:0] pad_oe,
    output logic             irq
);

    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic [WIDTH-1:0] dir_q, dir_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] edge_cap_q, edge_cap_d;
    logic [WIDTH-1:0] clr_bits;
    logic [WIDTH-1:0] sync;
    logic [WIDTH-1:0] edge_pulse;
    logic [WIDTH-1:0] wd;
    logic [31:0]      writedata_unused;
    logic             wr_en;

    assign wr_en            = chipselect && !write_n;
    assign wd               = writedata[WIDTH-1:0];
    assign writedata_unused = writedata;

    nios_gpio_sync_edge #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES),
        .EDGE_TYPE   (EDGE_TYPE)
    ) u_sync_edge (
        .clk        (clk),
        .reset_n    (reset_n),
        .pad_in     (pad_in),
        .sync       (sync),
        .edge_pulse (edge_pulse)
    );

    always_comb begin
        data_out_d = data_out_q;
        dir_d      = dir_q;
        mask_d     = mask_q;
        clr_bits   = '0;
        if (wr_en) begin
            case (address)
                ADDR_DATA: data_out_d = wd;
                ADDR_DIR:  dir_d      = wd;
                ADDR_MASK: mask_d     = wd;
                ADDR_EDGE: clr_bits   = wd;
                ADDR_SET:  data_out_d = data_out_q | wd;
                ADDR_CLR:  data_out_d = data_out_q & ~wd;
                default:   ;
            endcase
        end
        // A new edge overrides a simultaneous write-1-clear so no event is lost.
        edge_cap_d = (edge_cap_q & ~clr_bits) | edge_pulse;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_out_q <= RESET_VALUE;
            dir_q      <= RESET_DIR;
            mask_q     <= '0;
            edge_cap_q <= '0;
        end else begin
            data_out_q <= data_out_d;
            dir_q      <= dir_d;
            mask_q     <= mask_d;
            edge_cap_q <= edge_cap_d;
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA: readdata = 32'(sync);
            ADDR_DIR:  readdata = 32'(dir_q);
            ADDR_MASK: readdata = 32'(mask_q);
            ADDR_EDGE: readdata = 32'(edge_cap_q);
            default:   readdata = '0;
        endcase
    end

    // Open-drain pads never drive high; a 1 is produced by releasing the pin.
    assign pad_out = (OPEN_DRAIN != 0) ? '0 : data_out_q;
    assign pad_oe  = (OPEN_DRAIN != 0) ? (dir_q & ~data_out_q) : dir_q;
    assign irq     = |(edge_cap_q & mask_q);

endmodule

// File: tb/tb_nios_gpio_pio.sv
// Bench for nios_gpio_pio: a push-pull rising-edge instance and an open-drain
// any-edge instance share one bus and pad inputs, checked against a model.
module tb_nios_gpio_pio;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [2:0]  address = '0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = '0;
    logic [6:0]  pad_in = '0;

    logic [31:0] rd_pp, rd_od;
    logic [6:0]  pad_out_pp, pad_oe_pp, pad_out_od, pad_oe_od;
    logic        irq_pp, irq_od;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    nios_gpio_pio #(
        .WIDTH(7), .RESET_VALUE(7'h55), .RESET_DIR(7'h7F),
        .OPEN_DRAIN(0), .EDGE_TYPE(0), .SYNC_STAGES(2)
    ) u_pp (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd_pp),
        .pad_in(pad_in), .pad_out(pad_out_pp), .pad_oe(pad_oe_pp), .irq(irq_pp)
    );

    nios_gpio_pio #(
        .WIDTH(7), .RESET_VALUE(7'h55), .RESET_DIR(7'h7F),
        .OPEN_DRAIN(1), .EDGE_TYPE(2), .SYNC_STAGES(2)
    ) u_od (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd_od),
        .pad_in(pad_in), .pad_out(pad_out_od), .pad_oe(pad_oe_od), .irq(irq_od)
    );

    // Model: register state plus the pad values seen at the last three clock edges.
    logic [6:0] m_data = 7'h55, m_dir = 7'h7F, m_mask = '0;
    logic [6:0] m_cap_pp = '0, m_cap_od = '0;
    logic [6:0] m_h0 = '0, m_h1 = '0, m_h2 = '0;
    logic [6:0] m_wd, m_clr, m_rise, m_fall;
    logic       m_wr;

    assign m_wr   = chipselect && !write_n;
    assign m_wd   = writedata[6:0];
    assign m_clr  = (m_wr && address == 3'd3) ? m_wd : 7'h00;
    assign m_rise = m_h1 & ~m_h2;
    assign m_fall = ~m_h1 & m_h2;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_data <= 7'h55; m_dir <= 7'h7F; m_mask <= '0;
            m_cap_pp <= '0; m_cap_od <= '0;
            m_h0 <= '0; m_h1 <= '0; m_h2 <= '0;
        end else begin
            if (m_wr) begin
                case (address)
                    3'd0: m_data <= m_wd;
                    3'd1: m_dir  <= m_wd;
                    3'd2: m_mask <= m_wd;
                    3'd4: m_data <= m_data | m_wd;
                    3'd5: m_data <= m_data & ~m_wd;
                    default: ;
                endcase
            end
            m_cap_pp <= (m_cap_pp & ~m_clr) | m_rise;
            m_cap_od <= (m_cap_od & ~m_clr) | m_rise | m_fall;
            m_h0 <= pad_in; m_h1 <= m_h0; m_h2 <= m_h1;
        end
    end

    function automatic logic [31:0] exp_rd(input logic [6:0] cap);
        case (address)
            3'd0: return 32'(m_h1);
            3'd1: return 32'(m_dir);
            3'd2: return 32'(m_mask);
            3'd3: return 32'(cap);
            default: return 32'h0;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check("pp_pad_out", 32'(pad_out_pp), 32'(m_data));
        check("pp_pad_oe",  32'(pad_oe_pp),  32'(m_dir));
        check("pp_irq",     32'(irq_pp),     32'(|(m_cap_pp & m_mask)));
        check("pp_readdata", rd_pp, exp_rd(m_cap_pp));
        check("od_pad_out", 32'(pad_out_od), 32'h0);
        check("od_pad_oe",  32'(pad_oe_od),  32'(m_dir & ~m_data));
        check("od_irq",     32'(irq_od),     32'(|(m_cap_od & m_mask)));
        check("od_readdata", rd_od, exp_rd(m_cap_od));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        step();
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic rd(input logic [2:0] a, input string name, input logic [31:0] exp);
        address = a;
        #1;
        check(name, rd_pp, exp);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;

        check("rst_pad_out", 32'(pad_out_pp), 32'h55);
        check("rst_pad_oe", 32'(pad_oe_pp), 32'h7F);
        check("rst_irq", 32'(irq_pp), 32'h0);
        check("rst_od_pad_oe", 32'(pad_oe_od), 32'h2A);
        rd(3'd1, "rst_dir_read", 32'h7F);
        rd(3'd3, "rst_edge_read", 32'h0);

        wr(3'd0, 32'hFFFF_FF0F);
        check("data_write", 32'(pad_out_pp), 32'h0F);
        wr(3'd4, 32'h30);
        check("outset", 32'(pad_out_pp), 32'h3F);
        wr(3'd5, 32'h01);
        check("outclr", 32'(pad_out_pp), 32'h3E);
        rd(3'd4, "outset_read", 32'h0);
        rd(3'd5, "outclr_read", 32'h0);
        wr(3'd6, 32'h7F);
        check("addr6_ignored", 32'(pad_out_pp), 32'h3E);
        rd(3'd7, "addr7_read", 32'h0);

        wr(3'd1, 32'h03);
        wr(3'd0, 32'h01);
        check("od_pad_oe", 32'(pad_oe_od), 32'h02);
        check("od_pad_out", 32'(pad_out_od), 32'h0);
        check("pp_pad_oe_dir", 32'(pad_oe_pp), 32'h03);

        wr(3'd2, 32'h04);
        rd(3'd2, "mask_read", 32'h04);
        pad_in[2] = 1'b1;
        step();
        rd(3'd0, "data_not_yet", 32'h0);
        step();
        rd(3'd0, "data_sync", 32'h04);
        rd(3'd3, "edge_not_yet", 32'h0);
        check("irq_not_yet", 32'(irq_pp), 32'h0);
        step();
        rd(3'd3, "edge_set", 32'h04);
        check("irq_set", 32'(irq_pp), 32'h1);
        wr(3'd3, 32'h04);
        check("irq_cleared", 32'(irq_pp), 32'h0);

        pad_in[2] = 1'b0;
        repeat (4) step();
        rd(3'd3, "fall_ignored", 32'h0);
        check("fall_no_irq", 32'(irq_pp), 32'h0);
        check("any_edge_fall", rd_od, 32'h04);
        check("any_edge_irq", 32'(irq_od), 32'h1);

        pad_in[1] = 1'b1;
        step();
        step();
        wr(3'd3, 32'h02);
        rd(3'd3, "clear_race", 32'h02);
        check("clear_race_od", rd_od, 32'h06);
        wr(3'd3, 32'h06);
        rd(3'd3, "cleared", 32'h0);

        pad_in[2] = 1'b1;
        repeat (3) step();
        check("pending_irq", 32'(irq_pp), 32'h1);
        address = 3'd3;
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_irq", 32'(irq_pp), 32'h0);
        check("async_rst_edge", rd_pp, 32'h0);
        check("async_rst_pad_out", 32'(pad_out_pp), 32'h55);
        check("async_rst_pad_oe", 32'(pad_oe_pp), 32'h7F);
        check("async_rst_od_irq", 32'(irq_od), 32'h0);
        step();
        reset_n = 1'b1;
        repeat (2) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
